// File: rtl/mux_2x1_arbiter.sv
// Two-input valid/ready merge with round-robin grant and a one-entry registered output slice.
// Out_Sel tags each word with its source (0 = channel 1, 1 = channel 2) for downstream routing.
module mux_2x1_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In1_Valid,
  input  logic [WIDTH-1:0] In1_Data,
  output logic             In1_Ready,
  input  logic             In2_Valid,
  input  logic [WIDTH-1:0] In2_Data,
  output logic             In2_Ready,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] Out_Data,
  output logic             Out_Sel,
  input  logic             Out_Ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             last;
  logic             load;
  logic             grant1, grant2;
  logic             accept;
  logic [WIDTH-1:0] data_q;
  logic             sel_q;

  assign Out_Valid = (state == FULL);
  assign Out_Data  = data_q;
  assign Out_Sel   = sel_q;

  // Slot is free or draining this cycle; on contention the channel that was not last wins.
  assign load   = ~Out_Valid | Out_Ready;
  assign grant1 = In1_Valid & (~In2_Valid | last);
  assign grant2 = In2_Valid & (~In1_Valid | ~last);

  assign In1_Ready = load & grant1 & ~Reset;
  assign In2_Ready = load & grant2 & ~Reset;
  assign accept    = In1_Ready | In2_Ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (Out_Ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= EMPTY;
      data_q <= '0;
      sel_q  <= 1'b0;
      last   <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_q <= In2_Ready ? In2_Data : In1_Data;
        sel_q  <= In2_Ready;
        last   <= In2_Ready;
      end
    end
  end

endmodule

// File: doc/mux_2x1_arbiter.md
# mux_2x1_arbiter

Merges two valid/ready input streams into one output stream. Round-robin arbitration decides which input goes next, and a one-entry registered output slice holds the result. `Out_Sel` tags each output word with its source, using the same select encoding as `demux_1x2` (0 → channel 1, 1 → channel 2), so a downstream demux can route responses back. The block sits at the merge point in front of a shared single-consumer resource.

## Interface
- `WIDTH`, default 8: data width of every data port.

- `Clk`  in  1  rising-edge clock; only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `In1_Valid`  in  1  channel 1 has a word.
- `In1_Data`  in  WIDTH  channel 1 word.
- `In1_Ready`  out  1  channel 1 word accepted this cycle when high with `In1_Valid`.
- `In2_Valid`  in  1  channel 2 has a word.
- `In2_Data`  in  WIDTH  channel 2 word.
- `In2_Ready`  out  1  channel 2 accept.
- `Out_Valid`  out  1  output register holds a word.
- `Out_Data`  out  WIDTH  output word.
- `Out_Sel`  out  1  source of `Out_Data`: 0 = channel 1, 1 = channel 2.
- `Out_Ready`  in  1  consumer takes the word when high with `Out_Valid`.

## Operation
- State: output slice FSM with states `EMPTY` (`Out_Valid`=0) and `FULL` (`Out_Valid`=1), plus a 1-bit `Last` register holding the source of the most recent accepted word.
- `Load` = `~Out_Valid | Out_Ready`. The slot is free, or is draining this cycle.
- Grant:
  - Only `In1_Valid` high → channel 1.
  - Only `In2_Valid` high → channel 2.
  - Both high → the channel that was not `Last` (`Last`=1 → channel 1; `Last`=0 → channel 2).
  - Neither high → no grant.
- `InX_Ready` = `Load & GrantX & ~Reset`. This is combinational. At most one `Ready` is high per cycle.
- A `Ready` may depend on the other channel's `Valid`. A channel may not make its `Valid` depend on its own `Ready`.
- On an accept at the clock edge:
  - `Out_Data` ← granted data.
  - `Out_Sel` ← 0 or 1 for the source.
  - `Last` ← same value as `Out_Sel`.
  - `Out_Valid` ← 1.
- `Load` with no input valid: `Out_Valid` ← 0. `Out_Data`, `Out_Sel` and `Last` hold.
- `FULL` with `Out_Ready`=0: all output registers hold, both `Ready` outputs are 0, and no word is dropped or overwritten.
- Transitions:
  - `EMPTY`→`FULL` on accept.
  - `FULL`→`FULL` on a stall, or on a drain with a simultaneous accept.
  - `FULL`→`EMPTY` on a drain with no accept.
- The input side carries no buffering beyond the single output register. Words are never duplicated, reordered within a channel, or lost.

## Timing
- Reset values, taking effect on the first edge with `Reset`=1: `Out_Valid`=0, `Out_Data`=0, `Out_Sel`=0, `Last`=1 (channel 1 wins the first contention).
- While `Reset`=1: `In1_Ready`=`In2_Ready`=0, and no accept occurs.
- Latency: a word accepted at edge N is visible on `Out_*` after edge N, one cycle.
- Throughput: 1 word/cycle when `Out_Ready` stays high. This holds across simultaneous drain and load in the same cycle.
- Contention with continuous `Out_Ready`: the grant strictly alternates 1,2,1,2…, and neither channel waits more than one accepted word.
- Reset mid-operation: a word held in the slice is discarded, the arbiter returns to channel-1 priority, and the cycle after `Reset` falls behaves like power-up.
- `Out_Data` and `Out_Sel` are stable whenever `Out_Valid`=1 and `Out_Ready`=0.

## Test plan
- **Reset:** hold `Reset` 2 cycles with both inputs valid.
  - → `Ready` outputs 0 throughout.
  - → `Out_Valid`=0, `Out_Data`=0x00, `Out_Sel`=0.
- **Single channel:** `In2` streams 0x10,0x11,0x12 back-to-back, `Out_Ready`=1, `In1` idle.
  - → outputs 0x10,0x11,0x12 on consecutive cycles, each one cycle after its accept, with `Out_Sel`=1.
- **Contention:** both channels continuously valid. `In1` sends 0xA0,0xA1; `In2` sends 0xB0,0xB1; `Out_Ready`=1.
  - → output order 0xA0(0), 0xB0(1), 0xA1(0), 0xB1(1).
- **Backpressure:** load 0x55 from `In1`, then drop `Out_Ready` for 3 cycles with `In2_Valid`=1 carrying 0x66.
  - → `Out_Data`=0x55 is held, and both `Ready` outputs are 0.
  - → when `Out_Ready` rises, 0x55 drains and 0x66 loads in the same cycle.
- **Reset mid-operation:** slice `FULL` with 0x77, `Out_Ready`=0, and `Reset` pulsed for 1 cycle.
  - → `Out_Valid`=0 next cycle.
  - → with both inputs then valid, channel 1 is granted first.
- **Idle drain:** slice `FULL` and consumed while no input is valid.
  - → `Out_Valid` goes to 0.
  - → `Out_Data` and `Out_Sel` retain their last values.
